// File: rtl/level_pkg.sv
// Shared encodings for the obstacle scheduler: obstacle kinds, lane heights and FSM states.
package level_pkg;

   typedef enum logic [1:0] {
      KIND_NONE = 2'd0,
      KIND_HIGH = 2'd1,
      KIND_LOW2 = 2'd2,
      KIND_LOW3 = 2'd3
   } kind_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FREEZE = 2'd2
   } state_t;

   localparam int Y_HIGH_A = 160;
   localparam int Y_HIGH_B = 200;
   localparam int Y_LOW    = 245;

   function automatic kind_t kind_of(input logic [1:0] r);
      kind_t k;
      case (r)
         2'd2:    k = KIND_LOW2;
         2'd3:    k = KIND_LOW3;
         default: k = KIND_HIGH;
      endcase
      return k;
   endfunction

   function automatic int lane_of(input logic [1:0] r);
      int v;
      case (r)
         2'd0:    v = Y_HIGH_A;
         2'd1:    v = Y_HIGH_B;
         default: v = Y_LOW;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/obs_slot.sv
// One obstacle slot: occupancy, kind, position, scroll and retirement.
module obs_slot
   import level_pkg::*;
#(
   parameter int CORDW   = 10,
   parameter int X_START = 780,
   parameter int X_END   = 80
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             move,
   input  logic             alloc,
   input  logic [1:0]       alloc_kind,
   input  logic [CORDW-1:0] alloc_y,
   input  logic [3:0]       step,
   output logic             busy,
   output logic [1:0]       kind,
   output logic [CORDW-1:0] x,
   output logic [CORDW-1:0] y,
   output logic             retire_hit,
   output logic             retire
);

   // One extra bit so X_END+step cannot wrap near the top of the coordinate range.
   logic [CORDW:0] retire_lim;

   assign retire_lim = (CORDW+1)'(X_END) + (CORDW+1)'(step);
   assign retire_hit = move & busy & ({1'b0, x} <= retire_lim);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy   <= 1'b0;
         kind   <= KIND_NONE;
         x      <= CORDW'(X_START);
         y      <= '0;
         retire <= 1'b0;
      end else begin
         retire <= 1'b0;
         if (clear) begin
            busy <= 1'b0;
            kind <= KIND_NONE;
            x    <= CORDW'(X_START);
            y    <= '0;
         end else if (alloc) begin
            busy <= 1'b1;
            kind <= alloc_kind;
            x    <= CORDW'(X_START);
            y    <= alloc_y;
         end else if (retire_hit) begin
            busy   <= 1'b0;
            kind   <= KIND_NONE;
            x      <= CORDW'(X_START);
            retire <= 1'b1;
         end else if (move && busy) begin
            x <= x - CORDW'(step);
         end
      end
   end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn/scroll scheduler: cooldown-paced allocation into NSLOT slots, scoring on retire.
// Optional SCROLL_SPEED_RAMP_EN raises the scroll step every RAMP_SPAWNS spawns.
//   state     | meaning
//   ST_IDLE   | all slots free, counters cleared, waiting for game_run
//   ST_RUN    | spawn_tick/move_tick processed
//   ST_FREEZE | everything held, strobes ignored
module obstacle_scheduler
   import level_pkg::*;
#(
   parameter int NSLOT       = 3,
   parameter int CORDW       = 10,
   parameter int COOLDOWN    = 18,
   parameter int X_START     = 780,
   parameter int X_END       = 80,
   parameter int RAMP_SPAWNS = 8,
   parameter int STEP_MAX    = 4
)(
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   game_run,
   input  logic                   game_clear,
   input  logic                   spawn_tick,
   input  logic                   move_tick,
   input  logic [12:0]            rand_val,
   output logic [NSLOT-1:0]       busy,
   output logic [2*NSLOT-1:0]     kind,
   output logic [CORDW*NSLOT-1:0] x,
   output logic [CORDW*NSLOT-1:0] y,
   output logic [3:0]             step,
   output logic                   spawn_pulse,
   output logic [NSLOT-1:0]       retire_pulse,
   output logic [15:0]            score
);

   localparam int CDW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

   state_t           state;
   logic [CDW-1:0]   cooldown;
   logic             running;
   logic             slot_clear;
   logic             do_move;
   logic             do_spawn;
   logic             cool_full;
   logic             found;
   logic [NSLOT-1:0] pick;
   logic [NSLOT-1:0] alloc;
   logic [NSLOT-1:0] retire_hit;
   logic [15:0]      ret_cnt;
   logic [16:0]      score_sum;
   logic [15:0]      score_next;
   logic [1:0]       new_kind;
   logic [CORDW-1:0] new_y;
   logic             unused_rand;

   assign unused_rand = ^rand_val[12:2];

   assign running    = (state == ST_RUN) && !game_clear;
   assign slot_clear = game_clear || (state == ST_IDLE);
   assign do_move    = running && move_tick;
   assign cool_full  = (cooldown == CDW'(COOLDOWN));
   assign do_spawn   = running && spawn_tick && cool_full && found;
   assign alloc      = pick & {NSLOT{do_spawn}};
   assign new_kind   = kind_of(rand_val[1:0]);
   assign new_y      = CORDW'(lane_of(rand_val[1:0]));

   // Allocation looks at start-of-cycle busy, so a slot retiring now stays unavailable.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
         if (!busy[i] && !found) begin
            pick[i] = 1'b1;
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      ret_cnt = '0;
      for (int i = 0; i < NSLOT; i++) begin
         ret_cnt = ret_cnt + {15'd0, retire_hit[i]};
      end
      score_sum  = {1'b0, score} + {1'b0, ret_cnt};
      score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      obs_slot #(
         .CORDW   (CORDW),
         .X_START (X_START),
         .X_END   (X_END)
      ) u_slot (
         .clk        (CLK),
         .rst        (RESET),
         .clear      (slot_clear),
         .move       (do_move),
         .alloc      (alloc[i]),
         .alloc_kind (new_kind),
         .alloc_y    (new_y),
         .step       (step),
         .busy       (busy[i]),
         .kind       (kind[2*i +: 2]),
         .x          (x[CORDW*i +: CORDW]),
         .y          (y[CORDW*i +: CORDW]),
         .retire_hit (retire_hit[i]),
         .retire     (retire_pulse[i])
      );
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= ST_IDLE;
         cooldown    <= '0;
         score       <= '0;
         spawn_pulse <= 1'b0;
      end else begin
         spawn_pulse <= do_spawn;
         if (game_clear) begin
            state    <= ST_IDLE;
            cooldown <= '0;
            score    <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  cooldown <= '0;
                  score    <= '0;
                  if (game_run) state <= ST_RUN;
               end
               ST_RUN: begin
                  if (!game_run) state <= ST_FREEZE;
                  // With every slot busy the cooldown parks at COOLDOWN until one frees.
                  if (spawn_tick) begin
                     if (!cool_full)    cooldown <= cooldown + 1'b1;
                     else if (do_spawn) cooldown <= '0;
                  end
                  score <= score_next;
               end
               ST_FREEZE: begin
                  if (game_run) state <= ST_RUN;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef SCROLL_SPEED_RAMP_EN
   localparam int RCW = (RAMP_SPAWNS < 2) ? 1 : $clog2(RAMP_SPAWNS);
   logic [RCW-1:0] spawn_cnt;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         step      <= 4'd1;
         spawn_cnt <= '0;
      end else if (slot_clear) begin
         step      <= 4'd1;
         spawn_cnt <= '0;
      end else if (do_spawn) begin
         if (spawn_cnt == RCW'(RAMP_SPAWNS - 1)) begin
            spawn_cnt <= '0;
            if (step < 4'(STEP_MAX)) step <= step + 4'd1;
         end else begin
            spawn_cnt <= spawn_cnt + 1'b1;
         end
      end
   end
`else
   localparam int unused_ramp = RAMP_SPAWNS + STEP_MAX;
   assign step = 4'd1;
`endif

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler against a slot-array reference model.
module tb_obstacle_scheduler;

   localparam int NSLOT    = 3;
   localparam int CORDW    = 10;
   localparam int COOLDOWN = 18;
   localparam int X_START  = 780;
   localparam int X_END    = 80;
   localparam int RAMP     = 8;
   localparam int STEP_MAX = 4;
`ifdef SCROLL_SPEED_RAMP_EN
   localparam int EXP_STEP8  = 2;
   localparam int EXP_STEP40 = 4;
`else
   localparam int EXP_STEP8  = 1;
   localparam int EXP_STEP40 = 1;
`endif

   logic                   CLK, RESET, game_run, game_clear, spawn_tick, move_tick;
   logic [12:0]            rand_val;
   logic [NSLOT-1:0]       busy, retire_pulse;
   logic [2*NSLOT-1:0]     kind;
   logic [CORDW*NSLOT-1:0] x, y;
   logic [3:0]             step;
   logic                   spawn_pulse;
   logic [15:0]            score;

   int checks = 0;
   int errors = 0;

   obstacle_scheduler #(
      .NSLOT(NSLOT), .CORDW(CORDW), .COOLDOWN(COOLDOWN), .X_START(X_START),
      .X_END(X_END), .RAMP_SPAWNS(RAMP), .STEP_MAX(STEP_MAX)
   ) dut (
      .CLK(CLK), .RESET(RESET), .game_run(game_run), .game_clear(game_clear),
      .spawn_tick(spawn_tick), .move_tick(move_tick), .rand_val(rand_val),
      .busy(busy), .kind(kind), .x(x), .y(y), .step(step),
      .spawn_pulse(spawn_pulse), .retire_pulse(retire_pulse), .score(score)
   );

   always #5 CLK = ~CLK;

   // Reference model: 0 idle, 1 run, 2 freeze; lane/kind picked from lookup tables.
   int m_state, m_cool, m_score, m_spawns;
   int m_busy[NSLOT], m_kind[NSLOT], m_x[NSLOT], m_y[NSLOT];
   bit m_spawn;
   bit [NSLOT-1:0] m_ret;
   int lane_tab[4] = '{160, 200, 245, 245};
   int kind_tab[4] = '{1, 1, 2, 3};

   function automatic int m_step();
`ifdef SCROLL_SPEED_RAMP_EN
      int s = 1 + m_spawns / RAMP;
      return (s > STEP_MAX) ? STEP_MAX : s;
`else
      return 1;
`endif
   endfunction

   function automatic void m_free_all();
      for (int i = 0; i < NSLOT; i++) begin
         m_busy[i] = 0; m_kind[i] = 0; m_x[i] = X_START; m_y[i] = 0;
      end
      m_cool = 0; m_score = 0; m_spawns = 0;
   endfunction

   function automatic void m_reset();
      m_free_all();
      m_state = 0; m_spawn = 0; m_ret = '0;
   endfunction

   function automatic void model_step(input logic run, clr, st, mt, input logic [12:0] r);
      int fs, s, ri;
      m_spawn = 0; m_ret = '0;
      if (clr) begin
         m_free_all(); m_state = 0;
      end else if (m_state == 0) begin
         m_free_all();
         if (run) m_state = 1;
      end else if (m_state == 2) begin
         if (run) m_state = 1;
      end else begin
         s = m_step(); fs = -1;
         for (int i = 0; i < NSLOT; i++) if (m_busy[i] == 0 && fs < 0) fs = i;
         if (mt) begin
            for (int i = 0; i < NSLOT; i++) begin
               if (m_busy[i] != 0) begin
                  if (m_x[i] <= X_END + s) begin
                     m_busy[i] = 0; m_kind[i] = 0; m_x[i] = X_START; m_ret[i] = 1'b1;
                     if (m_score < 65535) m_score++;
                  end else begin
                     m_x[i] = m_x[i] - s;
                  end
               end
            end
         end
         if (st) begin
            if (m_cool < COOLDOWN) m_cool++;
            else if (fs >= 0) begin
               ri = int'(r[1:0]);
               m_busy[fs] = 1; m_kind[fs] = kind_tab[ri]; m_y[fs] = lane_tab[ri];
               m_x[fs] = X_START; m_cool = 0; m_spawn = 1; m_spawns++;
            end
         end
         if (!run) m_state = 2;
      end
   endfunction

   function automatic logic [NSLOT-1:0] exp_busy();
      logic [NSLOT-1:0] v;
      for (int i = 0; i < NSLOT; i++) v[i] = (m_busy[i] != 0);
      return v;
   endfunction

   function automatic logic [2*NSLOT-1:0] exp_kind();
      logic [2*NSLOT-1:0] v;
      for (int i = 0; i < NSLOT; i++) v[2*i +: 2] = 2'(m_kind[i]);
      return v;
   endfunction

   function automatic logic [CORDW*NSLOT-1:0] exp_x();
      logic [CORDW*NSLOT-1:0] v;
      for (int i = 0; i < NSLOT; i++) v[CORDW*i +: CORDW] = CORDW'(m_x[i]);
      return v;
   endfunction

   function automatic logic [CORDW*NSLOT-1:0] exp_y();
      logic [CORDW*NSLOT-1:0] v;
      for (int i = 0; i < NSLOT; i++) v[CORDW*i +: CORDW] = CORDW'(m_y[i]);
      return v;
   endfunction

   task automatic tick(input logic run, clr, st, mt, input logic [12:0] r);
      game_run = run; game_clear = clr; spawn_tick = st; move_tick = mt; rand_val = r;
      model_step(run, clr, st, mt, r);
      @(posedge CLK); #1;
   endtask

   task automatic spawn_one();
      int n = 0;
      do begin
         tick(1, 0, 1, 0, 13'($urandom));
         n++;
      end while (!m_spawn && n < COOLDOWN + 3);
   endtask

   task automatic restart();
      tick(1, 1, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      @(posedge CLK); #2;
      RESET = 1'b1; #1;
      m_reset();
      checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (x !== exp_x()) begin errors++; $display("FAIL reset_x got %h want %h", x, exp_x()); end
      checks++; if (y !== '0 || kind !== '0) begin errors++; $display("FAIL reset_y_kind got %h/%h want 0/0", y, kind); end
      checks++; if (step !== 4'd1 || score !== 16'd0) begin errors++; $display("FAIL reset_step_score got %0d/%0d want 1/0", step, score); end
      checks++; if (spawn_pulse !== 1'b0 || retire_pulse !== '0) begin errors++; $display("FAIL reset_pulses got %b/%b want 0/0", spawn_pulse, retire_pulse); end
      @(posedge CLK); #1;
      RESET = 1'b0;
   endtask

   task automatic test_first_spawn();
      tick(1, 0, 0, 0, 0);
      for (int k = 0; k < COOLDOWN; k++) begin
         tick(1, 0, 1, 0, 13'($urandom));
         checks++; if (spawn_pulse !== 1'b0) begin errors++; $display("FAIL early_spawn tick %0d got 1 want 0", k); end
      end
      tick(1, 0, 1, 0, 13'd2);
      checks++; if (spawn_pulse !== 1'b1) begin errors++; $display("FAIL first_spawn_pulse got %b want 1", spawn_pulse); end
      checks++; if (busy !== 3'b001) begin errors++; $display("FAIL first_spawn_busy got %b want 001", busy); end
      checks++; if (kind[1:0] !== 2'd2) begin errors++; $display("FAIL first_spawn_kind got %0d want 2", kind[1:0]); end
      checks++; if (y[CORDW-1:0] !== 10'd245) begin errors++; $display("FAIL first_spawn_y got %0d want 245", y[CORDW-1:0]); end
      checks++; if (x[CORDW-1:0] !== 10'd780) begin errors++; $display("FAIL first_spawn_x got %0d want 780", x[CORDW-1:0]); end
      tick(1, 0, 0, 0, 0);
      checks++; if (spawn_pulse !== 1'b0) begin errors++; $display("FAIL spawn_pulse_width got %b want 0", spawn_pulse); end
   endtask

   task automatic test_retire();
      int fired_at = -1;
      for (int k = 1; k <= 700; k++) begin
         tick(1, 0, 0, 1, 0);
         if (retire_pulse[0] === 1'b1 && fired_at < 0) fired_at = k;
         checks++; if (retire_pulse !== m_ret) begin errors++; $display("FAIL retire_pulse k=%0d got %b want %b", k, retire_pulse, m_ret); end
         if (k == 699) begin
            checks++; if (x[CORDW-1:0] !== 10'd81) begin errors++; $display("FAIL pre_retire_x got %0d want 81", x[CORDW-1:0]); end
         end
      end
      checks++; if (fired_at != 700) begin errors++; $display("FAIL retire_tick got %0d want 700", fired_at); end
      checks++; if (score !== 16'd1) begin errors++; $display("FAIL retire_score got %0d want 1", score); end
      checks++; if (x[CORDW-1:0] !== 10'd780 || busy[0] !== 1'b0) begin errors++; $display("FAIL retire_slot got x=%0d busy=%b want 780/0", x[CORDW-1:0], busy[0]); end
   endtask

   task automatic test_full();
      int n = 0;
      restart();
      spawn_one(); repeat (50) tick(1, 0, 0, 1, 0);
      spawn_one(); repeat (50) tick(1, 0, 0, 1, 0);
      spawn_one();
      checks++; if (busy !== 3'b111 || x !== exp_x()) begin errors++; $display("FAIL full_fill got %b %h want 111 %h", busy, x, exp_x()); end
      for (int k = 0; k < 40; k++) begin
         tick(1, 0, 1, 0, 13'($urandom));
         checks++; if (spawn_pulse !== 1'b0 || busy !== 3'b111) begin errors++; $display("FAIL full_nospawn k=%0d got %b/%b want 0/111", k, spawn_pulse, busy); end
      end
      while (retire_pulse === '0 && n < 1000) begin
         tick(1, 0, 0, 1, 0);
         n++;
      end
      checks++; if (retire_pulse !== 3'b001) begin errors++; $display("FAIL full_retire got %b want 001 after %0d", retire_pulse, n); end
      tick(1, 0, 1, 0, 13'd3);
      checks++; if (spawn_pulse !== 1'b1 || busy !== 3'b111) begin errors++; $display("FAIL full_respawn got %b/%b want 1/111", spawn_pulse, busy); end
      checks++; if (kind[1:0] !== 2'd3 || x[CORDW-1:0] !== 10'd780) begin errors++; $display("FAIL full_respawn_slot got %0d/%0d want 3/780", kind[1:0], x[CORDW-1:0]); end
   endtask

   task automatic test_freeze();
      logic [CORDW*NSLOT-1:0] frozen;
      tick(0, 0, 0, 0, 0);
      frozen = exp_x();
      checks++; if (x !== frozen) begin errors++; $display("FAIL freeze_entry got %h want %h", x, frozen); end
      for (int k = 0; k < 5; k++) begin
         tick(0, 0, 1, 1, 13'($urandom));
         checks++; if (x !== frozen || spawn_pulse !== 1'b0) begin errors++; $display("FAIL freeze_hold k=%0d got %h want %h", k, x, frozen); end
      end
      tick(1, 0, 0, 1, 0);
      checks++; if (x !== frozen) begin errors++; $display("FAIL freeze_exit got %h want %h", x, frozen); end
      tick(1, 0, 0, 1, 0);
      checks++; if (int'(x[CORDW-1:0]) != int'(frozen[CORDW-1:0]) - 1 || x !== exp_x()) begin
         errors++; $display("FAIL freeze_resume got %0d want %0d", x[CORDW-1:0], int'(frozen[CORDW-1:0]) - 1);
      end
   endtask

   task automatic test_same_cycle();
      int n = 0;
      restart();
      spawn_one(); repeat (200) tick(1, 0, 0, 1, 0);
      spawn_one();
      while (m_busy[0] != 0 && n < 2000) begin tick(1, 0, 0, 1, 0); n++; end
      spawn_one();
      while (m_x[1] > X_END + 1 && n < 4000) begin tick(1, 0, 0, 1, 0); n++; end
      while (m_cool < COOLDOWN && n < 4100) begin tick(1, 0, 1, 0, 13'($urandom)); n++; end
      checks++; if (busy !== 3'b011 || x[CORDW +: CORDW] !== 10'd81) begin errors++; $display("FAIL same_setup got %b x1=%0d want 011/81", busy, x[CORDW +: CORDW]); end
      tick(1, 0, 1, 1, 13'($urandom));
      checks++; if (retire_pulse !== 3'b010 || spawn_pulse !== 1'b1) begin errors++; $display("FAIL same_pulses got %b/%b want 010/1", retire_pulse, spawn_pulse); end
      checks++; if (busy !== 3'b101) begin errors++; $display("FAIL same_busy got %b want 101", busy); end
      checks++; if (x[2*CORDW +: CORDW] !== 10'd780 || x !== exp_x()) begin errors++; $display("FAIL same_x got %h want %h", x, exp_x()); end
   endtask

   task automatic test_random();
      logic clr, run, st, mt;
      for (int k = 0; k < 2000; k++) begin
         clr = ($urandom_range(0, 199) == 0);
         run = ($urandom_range(0, 15) != 0);
         st  = $urandom_range(0, 1) != 0;
         mt  = $urandom_range(0, 1) != 0;
         tick(run, clr, st, mt, 13'($urandom));
         checks++; if (busy !== exp_busy() || kind !== exp_kind()) begin errors++; $display("FAIL rnd_slots k=%0d got %b/%h want %b/%h", k, busy, kind, exp_busy(), exp_kind()); end
         checks++; if (x !== exp_x() || y !== exp_y()) begin errors++; $display("FAIL rnd_xy k=%0d got %h/%h want %h/%h", k, x, y, exp_x(), exp_y()); end
         checks++; if (spawn_pulse !== m_spawn || retire_pulse !== m_ret) begin errors++; $display("FAIL rnd_pulses k=%0d got %b/%b want %b/%b", k, spawn_pulse, retire_pulse, m_spawn, m_ret); end
         checks++; if (int'(score) != m_score || int'(step) != m_step()) begin errors++; $display("FAIL rnd_score_step k=%0d got %0d/%0d want %0d/%0d", k, score, step, m_score, m_step()); end
      end
   endtask

   task automatic test_ramp();
      int n = 0;
      restart();
      while (m_spawns < 40 && n < 30000) begin
         tick(1, 0, 1, 1, 13'($urandom));
         n++;
         checks++; if (int'(step) != m_step() || x !== exp_x()) begin errors++; $display("FAIL ramp_track n=%0d got %0d want %0d", n, step, m_step()); end
         if (m_spawn && m_spawns == 8) begin
            checks++; if (int'(step) != EXP_STEP8) begin errors++; $display("FAIL ramp_step8 got %0d want %0d", step, EXP_STEP8); end
         end
         if (m_spawn && m_spawns == 40) begin
            checks++; if (int'(step) != EXP_STEP40) begin errors++; $display("FAIL ramp_step40 got %0d want %0d", step, EXP_STEP40); end
         end
      end
      checks++; if (m_spawns < 40) begin errors++; $display("FAIL ramp_timeout got %0d spawns want 40", m_spawns); end
      tick(1, 1, 0, 0, 0);
      checks++; if (step !== 4'd1 || busy !== '0 || score !== 16'd0) begin errors++; $display("FAIL ramp_clear got %0d/%b/%0d want 1/000/0", step, busy, score); end
   endtask

   task automatic test_reset_mid();
      tick(1, 0, 0, 0, 0);
      spawn_one(); repeat (10) tick(1, 0, 0, 1, 0);
      #2; RESET = 1'b1; #1;
      m_reset();
      checks++; if (busy !== '0 || x !== exp_x() || score !== 16'd0) begin errors++; $display("FAIL mid_reset got %b/%h want 000/%h", busy, x, exp_x()); end
      @(posedge CLK); #1; RESET = 1'b0;
      tick(1, 0, 0, 0, 0);
      spawn_one();
      checks++; if (busy !== 3'b001 || x !== exp_x() || spawn_pulse !== 1'b1) begin errors++; $display("FAIL mid_resume got %b/%h want 001/%h", busy, x, exp_x()); end
   endtask

   initial begin
      CLK = 1'b0; RESET = 1'b1;
      game_run = 1'b0; game_clear = 1'b0; spawn_tick = 1'b0; move_tick = 1'b0; rand_val = '0;
      m_reset();
      repeat (2) @(posedge CLK);
      #1; RESET = 1'b0;
      test_reset();
      test_first_spawn();
      test_retire();
      test_full();
      test_freeze();
      test_same_cycle();
      test_random();
      test_ramp();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 SHALL have parameter NSLOT, default 3, number of obstacle slots.
REQ-002 SHALL have parameter CORDW, default 10, coordinate width.
REQ-003 SHALL have parameter COOLDOWN, default 18, spawn_tick count between spawns.
REQ-004 SHALL have parameter X_START, default 780, spawn x; parameter X_END, default 80, retire x.
REQ-005 SHALL have parameter RAMP_SPAWNS, default 8, spawns per speed step; parameter STEP_MAX, default 4.
REQ-006 SHALL have ports, in order: CLK in 1 system clock; RESET in 1 asynchronous active-high reset.
REQ-007 SHALL have ports: game_run in 1 gameplay active; game_clear in 1 new-game clear; spawn_tick in 1 cooldown strobe; move_tick in 1 scroll strobe; rand in 13 LFSR value.
REQ-008 SHALL have outputs: busy out NSLOT slot occupied; kind out 2*NSLOT slot type; x out CORDW*NSLOT slot x; y out CORDW*NSLOT slot y; step out 4 scroll step; spawn_pulse out 1; retire_pulse out NSLOT; score out 16 retired-obstacle count.

Function
REQ-009 SHALL implement FSM IDLE/RUN/FREEZE; game_clear forces IDLE from any state, highest priority.
REQ-010 SHALL go IDLE->RUN and FREEZE->RUN on game_run=1; RUN->FREEZE on game_run=0.
REQ-011 SHALL, in IDLE, hold all slots free: busy=0, kind=NONE, x=X_START, y=0, cooldown=0, score=0, step=1.
REQ-012 SHALL, in FREEZE, hold every register; ticks ignored.
REQ-013 SHALL, in RUN on spawn_tick with cooldown<COOLDOWN, increment cooldown.
REQ-014 SHALL, in RUN on spawn_tick with cooldown==COOLDOWN and a free slot, allocate lowest-index free slot, clear cooldown, pulse spawn_pulse one cycle.
REQ-015 SHALL, with no free slot, hold cooldown at COOLDOWN (spawn fires on first spawn_tick after a slot frees).
REQ-016 SHALL select kind from rand[1:0]: 0 -> HIGH y=160; 1 -> HIGH y=200; 2 -> LOW2 y=245; 3 -> LOW3 y=245; new slot x=X_START.
REQ-017 SHALL encode kind NONE=0, HIGH=1, LOW2=2, LOW3=3.
REQ-018 SHALL, in RUN on move_tick, set busy slot x <= x-step when x > X_END+step.
REQ-019 SHALL, when busy slot x <= X_END+step on move_tick, retire it: busy=0, kind=NONE, x=X_START, retire_pulse bit high one cycle, score+1 saturating at 16'hFFFF.
REQ-020 SHALL evaluate allocation on start-of-cycle busy: slot spawned this cycle not moved; slot retired this cycle not reallocated this cycle.
REQ-021 SHALL register all outputs; effects visible the cycle after the strobe.
REQ-022 SHALL never underflow x (arithmetic in CORDW bits, retire check precedes subtract).

Reset
REQ-023 SHALL on RESET, asynchronously: state=IDLE, busy=0, kind=0, x=X_START, y=0, step=1, cooldown=0, score=0, spawn_pulse=0, retire_pulse=0.
REQ-024 SHALL resume from IDLE after RESET deasserts mid-operation; no slot state retained.

Configuration
REQ-025 SHALL, with SCROLL_SPEED_RAMP_EN defined, increment step by 1 after every RAMP_SPAWNS spawns, saturating at STEP_MAX, returned to 1 by game_clear.
REQ-026 SHALL, without SCROLL_SPEED_RAMP_EN, tie step to constant 1 and omit the spawn counter.

Structure
REQ-027 SHALL place kind encoding, y lane constants (160/200/245) and FSM state encoding in shared package level_pkg.
REQ-028 SHALL instantiate per-slot sub-module obs_slot (busy/kind/x/y registers, move and retire logic) NSLOT times; allocation and cooldown stay in top.

Verification
REQ-029 SHALL test: RESET, game_run=1, 18 spawn_ticks then 1 more with rand=2 -> slot0 busy, kind=2, y=245, x=780, spawn_pulse once.
REQ-030 SHALL test: slot0 at x=780, 700 move_ticks step=1 -> retire_pulse[0] when x reaches 81, score=1, x=780.
REQ-031 SHALL test: all 3 slots busy, 40 spawn_ticks -> no spawn, cooldown held 18; first spawn_tick after retire -> slot allocated.
REQ-032 SHALL test: game_run=0 mid-run with 5 move_ticks -> x unchanged; game_run=1 -> movement resumes.
REQ-033 SHALL test: spawn_tick and move_tick same cycle while slot1 retires -> slot1 not reused, slot2 spawned at 780 unmoved.
REQ-034 SHALL test: SCROLL_SPEED_RAMP_EN defined, 8 spawns -> step=2; 40 spawns -> step=4 saturated; game_clear -> step=1.
